// File: rtl/core_pipe_pkg.sv
// Shared widths and control-bit positions for the core's inter-stage pipeline bundles,
// plus the slot operation encoding used by the elastic stage.
package core_pipe_pkg;

  localparam int D_CTRL_W = 8;
  localparam int D_DATA_W = 64;
  localparam int E_CTRL_W = 8;
  localparam int E_DATA_W = 64;
  localparam int M_CTRL_W = 6;
  localparam int M_DATA_W = 64;
  localparam int W_CTRL_W = 2;
  localparam int W_DATA_W = 64;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_SPARE      = 7;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_LOAD_IN,
    SLOT_LOAD_SKID,
    SLOT_DRAIN
  } slot_op_e;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// One valid/ready link between two core stages, carrying a control and a data field.
interface pipe_stage_elastic_if
  import core_pipe_pkg::*;
#(
  parameter int DATA_W = E_DATA_W,
  parameter int CTRL_W = E_CTRL_W
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_slot.sv
// One pipeline register slot: valid bit plus control and data fields.
// Draining clears valid and control but keeps the data bits untouched.
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  input  logic              load,
  input  logic              zero_ctrl,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (zero_ctrl) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with an optional second (skid) slot so that
// in_ready can come straight from a register instead of from downstream ready.
module pipe_stage_elastic
  import core_pipe_pkg::*;
#(
  parameter int DATA_W = E_DATA_W,
  parameter int CTRL_W = E_CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  Flush,
  pipe_stage_elastic_if.slave   up,
  pipe_stage_elastic_if.master  dn,
  output logic [1:0]            occupancy
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
  logic              xfer_in, xfer_out;
  slot_op_e          main_op, skid_op;

  assign xfer_out = main_v & dn.ready;
  assign xfer_in  = up.valid & up.ready;
  assign up.ready = SKID ? ~skid_v : (~main_v | dn.ready);

  // The skid entry is always older than anything arriving, so it refills main first.
  always_comb begin
    main_op = SLOT_HOLD;
    if (SKID && skid_v && xfer_out)
      main_op = SLOT_LOAD_SKID;
    else if (xfer_in && (!main_v || xfer_out))
      main_op = SLOT_LOAD_IN;
    else if (xfer_out)
      main_op = SLOT_DRAIN;
  end

  always_comb begin
    skid_op = SLOT_HOLD;
    if (SKID && xfer_in && main_v && !xfer_out)
      skid_op = SLOT_LOAD_IN;
    else if (skid_v && xfer_out)
      skid_op = SLOT_DRAIN;
  end

  assign main_ld_ctrl = (main_op == SLOT_LOAD_SKID) ? skid_ctrl : up.ctrl;
  assign main_ld_data = (main_op == SLOT_LOAD_SKID) ? skid_data : up.data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear     (Flush),
    .load      ((main_op == SLOT_LOAD_SKID) || (main_op == SLOT_LOAD_IN)),
    .zero_ctrl (main_op == SLOT_DRAIN),
    .ld_ctrl   (main_ld_ctrl),
    .ld_data   (main_ld_data),
    .valid     (main_v),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (Flush),
        .load      (skid_op == SLOT_LOAD_IN),
        .zero_ctrl (skid_op == SLOT_DRAIN),
        .ld_ctrl   (up.ctrl),
        .ld_data   (up.data),
        .valid     (skid_v),
        .ctrl      (skid_ctrl),
        .data      (skid_data)
      );
    end else begin : g_no_skid
      assign skid_v    = 1'b0;
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

  assign dn.valid  = main_v;
  assign dn.ctrl   = main_ctrl;
  assign dn.data   = main_data;
  assign occupancy = occ_count(main_v, skid_v);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives a SKID=1 and a SKID=0 stage with identical stimulus; each is checked
// against a queue model of an ordered stage holding at most 2 (or 1) entries.
module tb_pipe_stage_elastic;

  localparam int DW = 64;
  localparam int CW = 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       flush;
  logic [1:0] occ1, occ0;
  int         checks = 0;
  int         errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) up1 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) dn1 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) up0 ();
  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) dn0 ();

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .Flush(flush), .up(up1), .dn(dn1), .occupancy(occ1));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .Flush(flush), .up(up0), .dn(dn0), .occupancy(occ0));

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  // Model: queue head is the entry on out_*; last* is what out_data shows when empty.
  ent_t          q1[$];
  ent_t          q0[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last0 = '0;

  task automatic applyStimulus(input logic rst, input logic fl, input logic v,
                               input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic ordy);
    RESET = rst;  flush = fl;
    up1.valid = v; up1.ctrl = c; up1.data = d;
    up0.valid = v; up0.ctrl = c; up0.data = d;
    dn1.ready = ordy; dn0.ready = ordy;
    #1;
  endtask

  task automatic advanceClock();
    logic rdy1, rdy0;
    ent_t e;
    rdy1   = (q1.size() < 2);
    rdy0   = (q0.size() == 0) || dn0.ready;
    e.ctrl = up1.ctrl;
    e.data = up1.data;
    @(posedge CLK);
    if (RESET || flush) begin
      q1.delete(); q0.delete();
      last1 = '0;  last0 = '0;
    end else begin
      if (q1.size() > 0 && dn1.ready) void'(q1.pop_front());
      if (up1.valid && rdy1) q1.push_back(e);
      if (q1.size() > 0) last1 = q1[0].data;
      if (q0.size() > 0 && dn0.ready) void'(q0.pop_front());
      if (up0.valid && rdy0) q0.push_back(e);
      if (q0.size() > 0) last0 = q0[0].data;
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 64'hDEAD_BEEF, 1'b0);
    advanceClock();
    advanceClock();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid1 got %b want 0", dn1.valid); end
    checks++; if (dn1.ctrl !== '0) begin errors++; $display("[TB] FAIL reset_ctrl1 got %h want 0", dn1.ctrl); end
    checks++; if (dn1.data !== '0) begin errors++; $display("[TB] FAIL reset_data1 got %h want 0", dn1.data); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ1 got %0d want 0", occ1); end
    checks++; if (up1.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready1 got %b want 1", up1.ready); end
    checks++; if (dn0.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid0 got %b want 0", dn0.valid); end
    checks++; if (dn0.ctrl !== '0) begin errors++; $display("[TB] FAIL reset_ctrl0 got %h want 0", dn0.ctrl); end
    checks++; if (dn0.data !== '0) begin errors++; $display("[TB] FAIL reset_data0 got %h want 0", dn0.data); end
    checks++; if (occ0 !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ0 got %0d want 0", occ0); end
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready0 got %b want 1", up0.ready); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, CW'(i), DW'(i), 1'b1);
      checks++; if (up1.ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready1 got %b want 1", up1.ready); end
      checks++; if (up0.ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready0 got %b want 1", up0.ready); end
      if (i > 1) begin
        checks++; if (dn1.valid !== 1'b1 || dn1.data !== DW'(i-1)) begin errors++; $display("[TB] FAIL stream_data1 got v=%b %0d want v=1 %0d", dn1.valid, dn1.data, i-1); end
        checks++; if (dn0.valid !== 1'b1 || dn0.data !== DW'(i-1)) begin errors++; $display("[TB] FAIL stream_data0 got v=%b %0d want v=1 %0d", dn0.valid, dn0.data, i-1); end
      end
      advanceClock();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
    checks++; if (dn1.data !== 64'd8 || dn1.ctrl !== 8'd8) begin errors++; $display("[TB] FAIL stream_last1 got %0d/%0d want 8/8", dn1.data, dn1.ctrl); end
    advanceClock();
    checks++; if (dn1.valid !== 1'b0 || dn1.ctrl !== '0 || dn1.data !== 64'd8) begin errors++; $display("[TB] FAIL stream_drain1 got v=%b c=%h d=%0d want v=0 c=0 d=8", dn1.valid, dn1.ctrl, dn1.data); end
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 64'hA, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 64'hB, 1'b0);
    checks++; if (occ1 !== 2'd1 || up1.ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_one got occ=%0d rdy=%b want 1/1", occ1, up1.ready); end
    advanceClock();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
    checks++; if (occ1 !== 2'd2 || up1.ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full got occ=%0d rdy=%b want 2/0", occ1, up1.ready); end
    advanceClock();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
    checks++; if (dn1.valid !== 1'b1 || dn1.data !== 64'hA || dn1.ctrl !== 8'h11) begin errors++; $display("[TB] FAIL bp_first got %h/%h want A/11", dn1.data, dn1.ctrl); end
    advanceClock();
    checks++; if (dn1.valid !== 1'b1 || dn1.data !== 64'hB || dn1.ctrl !== 8'h22) begin errors++; $display("[TB] FAIL bp_second got %h/%h want B/22", dn1.data, dn1.ctrl); end
    checks++; if (occ1 !== 2'd1 || up1.ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got occ=%0d rdy=%b want 1/1", occ1, up1.ready); end
    advanceClock();
    checks++; if (occ1 !== 2'd0 || dn1.valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got occ=%0d v=%b want 0/0", occ1, dn1.valid); end
  endtask

  task automatic test_flush();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 64'hC, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h44, 64'hD, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 64'hE, 1'b0);
    checks++; if (occ1 !== 2'd2) begin errors++; $display("[TB] FAIL flush_pre_occ got %0d want 2", occ1); end
    advanceClock();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
      checks++; if (dn1.valid !== 1'b0 || dn1.ctrl !== '0 || occ1 !== 2'd0) begin errors++; $display("[TB] FAIL flush_clear1 got v=%b c=%h occ=%0d want 0/0/0", dn1.valid, dn1.ctrl, occ1); end
      checks++; if (dn1.data !== '0) begin errors++; $display("[TB] FAIL flush_data1 got %h want 0", dn1.data); end
      checks++; if (dn0.valid !== 1'b0 || dn0.ctrl !== '0 || occ0 !== 2'd0) begin errors++; $display("[TB] FAIL flush_clear0 got v=%b c=%h occ=%0d want 0/0/0", dn0.valid, dn0.ctrl, occ0); end
      advanceClock();
    end
  endtask

  task automatic test_skid0();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h51, 64'h51, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h52, 64'h52, 1'b0);
    checks++; if (up0.ready !== 1'b0 || dn0.data !== 64'h51) begin errors++; $display("[TB] FAIL s0_stall got rdy=%b d=%h want 0/51", up0.ready, dn0.data); end
    advanceClock();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, CW'(8'h60 + k), DW'(64'h60 + k), 1'b1);
      checks++; if (up0.ready !== 1'b1) begin errors++; $display("[TB] FAIL s0_ready got %b want 1", up0.ready); end
      checks++; if (dn0.valid !== 1'b1 || dn0.data !== ((k == 0) ? 64'h51 : DW'(64'h5F + k))) begin errors++; $display("[TB] FAIL s0_replace k=%0d got v=%b d=%h", k, dn0.valid, dn0.data); end
      advanceClock();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
    checks++; if (dn0.data !== 64'h63 || occ0 !== 2'd1) begin errors++; $display("[TB] FAIL s0_tail got d=%h occ=%0d want 63/1", dn0.data, occ0); end
    advanceClock();
  endtask

  task automatic test_random();
    logic [DW-1:0] act[10];
    logic [DW-1:0] expv[10];
    string         nm[10];
    int            vp, rp;
    nm = '{"rand_in_ready1", "rand_valid1", "rand_ctrl1", "rand_data1", "rand_occ1",
           "rand_in_ready0", "rand_valid0", "rand_ctrl0", "rand_data0", "rand_occ0"};
    for (int cyc = 0; cyc < 10000; cyc++) begin
      vp = (cyc / 2500 == 1) ? 3 : 1;
      rp = (cyc / 2500 == 2) ? 3 : 1;
      applyStimulus($urandom_range(0, 2999) == 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, vp) != 0, CW'($urandom_range(1, 255)),
                    {$urandom, $urandom}, $urandom_range(0, rp) != 0);
      act[0] = DW'(up1.ready); expv[0] = DW'(q1.size() < 2);
      act[1] = DW'(dn1.valid); expv[1] = DW'(q1.size() > 0);
      act[2] = DW'(dn1.ctrl);  expv[2] = (q1.size() > 0) ? DW'(q1[0].ctrl) : '0;
      act[3] = dn1.data;       expv[3] = (q1.size() > 0) ? q1[0].data : last1;
      act[4] = DW'(occ1);      expv[4] = DW'(q1.size());
      act[5] = DW'(up0.ready); expv[5] = DW'((q0.size() == 0) || dn0.ready);
      act[6] = DW'(dn0.valid); expv[6] = DW'(q0.size() > 0);
      act[7] = DW'(dn0.ctrl);  expv[7] = (q0.size() > 0) ? DW'(q0[0].ctrl) : '0;
      act[8] = dn0.data;       expv[8] = (q0.size() > 0) ? q0[0].data : last0;
      act[9] = DW'(occ0);      expv[9] = DW'(q0.size());
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (act[j] !== expv[j]) begin
          errors++;
          $display("[TB] FAIL %s cycle %0d got %h want %h", nm[j], cyc, act[j], expv[j]);
        end
      end
      advanceClock();
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
